// File: rtl/async_mem_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the asynchronous-memory arbiter.
package async_mem_arbiter_pkg;

    typedef enum logic {
        PRIO_FIXED = 1'b0,
        PRIO_RR    = 1'b1
    } arb_mode_t;

    localparam int MAX_N     = 16;
    localparam int MAX_IDX_W = 4;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // First requester strictly after ptr, wrapping modulo n. Passing ptr = n-1
    // yields plain lowest-index priority.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                      input logic [MAX_IDX_W-1:0] ptr,
                                      input int n);
        pick_t r;
        int    j;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 1; k <= MAX_N; k++) begin
            j = (int'(ptr) + k) % n;
            if (k <= n && !r.found && req[MAX_IDX_W'(j)]) begin
                r.found = 1'b1;
                r.idx   = MAX_IDX_W'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/async_mem_index_fifo.sv
// FIFO of channel indices for outstanding reads; head is the channel owed the next response.
module async_mem_index_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is only honoured when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop  = pop & (count_reg != '0);
        do_push = push & ((count_reg != CNT_W'(DEPTH)) | do_pop);
    end

    // Storage array; no reset needed since count gates every read.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);

endmodule

// File: rtl/async_mem_arbiter_n.sv
// N-channel arbiter onto one asynchronous-memory port, with multiple outstanding reads
// whose responses are routed back through a channel-index FIFO.
module async_mem_arbiter_n
    import async_mem_arbiter_pkg::*;
#(
    parameter int        N           = 2,
    parameter int        ADDR_WIDTH  = 7,
    parameter int        DATA_WIDTH  = 16,
    parameter int        MAX_PENDING = 4,
    parameter arb_mode_t MODE        = PRIO_FIXED
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N-1:0]                       io_in_rd,
    input  logic [N-1:0]                       io_in_wr,
    input  logic [N*ADDR_WIDTH-1:0]            io_in_addr,
    input  logic [N*DATA_WIDTH-1:0]            io_in_din,
    output logic [N*DATA_WIDTH-1:0]            io_in_dout,
    output logic [N-1:0]                       io_in_wait_n,
    output logic [N-1:0]                       io_in_valid,
    output logic                               io_out_rd,
    output logic                               io_out_wr,
    output logic [ADDR_WIDTH-1:0]              io_out_addr,
    output logic [DATA_WIDTH-1:0]              io_out_din,
    input  logic [DATA_WIDTH-1:0]              io_out_dout,
    input  logic                               io_out_wait_n,
    input  logic                               io_out_valid,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
    output logic                               err_valid
);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    logic [N-1:0]     req;
    pick_t            pick;
    logic             grant_vld;
    logic [IDX_W-1:0] grant;
    logic             read_block, accept, zero_lat, push, pop, stray;
    logic [IDX_W-1:0] head;
    logic [CNT_W-1:0] count;
    logic             empty;

    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic             lock_reg, lock_next;
    logic [IDX_W-1:0] lock_idx_reg, lock_idx_next;
    logic             err_reg, err_next;

    assign req = io_in_rd | io_in_wr;

    // Grant selection, downstream muxing, acceptance and read-return routing.
    always_comb begin
        pick = rr_pick(MAX_N'(req),
                       (MODE == PRIO_RR) ? MAX_IDX_W'(rr_ptr_reg) : MAX_IDX_W'(N - 1), N);
        if (lock_reg) begin
            grant_vld = 1'b1;
            grant     = lock_idx_reg;
        end else begin
            grant_vld = pick.found;
            grant     = pick.idx[IDX_W-1:0];
        end
        read_block  = grant_vld & io_in_rd[grant] & (count == CNT_W'(MAX_PENDING));
        io_out_rd   = grant_vld & io_in_rd[grant] & ~read_block;
        io_out_wr   = grant_vld & io_in_wr[grant];
        io_out_addr = grant_vld ? io_in_addr[grant*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        io_out_din  = grant_vld ? io_in_din[grant*DATA_WIDTH +: DATA_WIDTH] : '0;
        accept      = grant_vld & req[grant] & io_out_wait_n & ~read_block;
        zero_lat    = accept & io_in_rd[grant] & empty & io_out_valid;
        push        = accept & io_in_rd[grant] & ~zero_lat;
        pop         = io_out_valid & ~empty;
        stray       = io_out_valid & empty & ~zero_lat;
        io_in_valid = '0;
        if (zero_lat)  io_in_valid[grant] = 1'b1;
        else if (pop)  io_in_valid[head]  = 1'b1;
    end

    // Lock holds a stalled grant until it is accepted or its requester gives up.
    always_comb begin
        lock_next     = lock_reg;
        lock_idx_next = lock_idx_reg;
        rr_ptr_next   = rr_ptr_reg;
        err_next      = err_reg | stray;
        if (accept) begin
            lock_next = 1'b0;
            if (MODE == PRIO_RR) rr_ptr_next = grant;
        end else if (grant_vld && req[grant]) begin
            lock_next     = 1'b1;
            lock_idx_next = grant;
        end else if (lock_reg) begin
            lock_next = 1'b0;
        end
    end

    // Arbiter state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_reg   <= IDX_W'(N - 1);
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            rr_ptr_reg   <= rr_ptr_next;
            lock_reg     <= lock_next;
            lock_idx_reg <= lock_idx_next;
            err_reg      <= err_next;
        end
    end

    async_mem_index_fifo #(
        .W     (IDX_W),
        .DEPTH (MAX_PENDING)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (grant),
        .pop   (pop),
        .head  (head),
        .count (count),
        .empty (empty)
    );

    // Per-channel read data fan-out and ready.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            assign io_in_dout[gi*DATA_WIDTH +: DATA_WIDTH] = io_out_dout;
            assign io_in_wait_n[gi] = io_out_wait_n & ~read_block &
                                      (~grant_vld | (grant == IDX_W'(gi)));
        end
    endgenerate

    assign pending   = count;
    assign err_valid = err_reg;

endmodule

// File: tb/tb_async_mem_arbiter_n.sv
// Directed bench: a fixed-priority instance (MAX_PENDING=2) and a round-robin instance
// (MAX_PENDING=4), both with four channels, driven through a linear step sequence.
module tb_async_mem_arbiter_n;
    import async_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Fixed-priority instance signals
    logic [3:0]  a_rd, a_wr, a_in_wait_n, a_in_valid;
    logic [27:0] a_addr;
    logic [63:0] a_din, a_in_dout;
    logic        a_out_rd, a_out_wr, a_out_wait_n, a_out_valid, a_err;
    logic [6:0]  a_out_addr;
    logic [15:0] a_out_din, a_out_dout;
    logic [1:0]  a_pending;

    // Round-robin instance signals
    logic [3:0]  b_rd, b_wr, b_in_wait_n, b_in_valid;
    logic [27:0] b_addr;
    logic [63:0] b_din, b_in_dout;
    logic        b_out_rd, b_out_wr, b_out_wait_n, b_out_valid, b_err;
    logic [6:0]  b_out_addr;
    logic [15:0] b_out_din, b_out_dout;
    logic [2:0]  b_pending;

    async_mem_arbiter_n #(.N(4), .ADDR_WIDTH(7), .DATA_WIDTH(16), .MAX_PENDING(2), .MODE(PRIO_FIXED)) dut_a (
        .clock(clk), .reset(reset),
        .io_in_rd(a_rd), .io_in_wr(a_wr), .io_in_addr(a_addr), .io_in_din(a_din),
        .io_in_dout(a_in_dout), .io_in_wait_n(a_in_wait_n), .io_in_valid(a_in_valid),
        .io_out_rd(a_out_rd), .io_out_wr(a_out_wr), .io_out_addr(a_out_addr), .io_out_din(a_out_din),
        .io_out_dout(a_out_dout), .io_out_wait_n(a_out_wait_n), .io_out_valid(a_out_valid),
        .pending(a_pending), .err_valid(a_err)
    );

    async_mem_arbiter_n #(.N(4), .ADDR_WIDTH(7), .DATA_WIDTH(16), .MAX_PENDING(4), .MODE(PRIO_RR)) dut_b (
        .clock(clk), .reset(reset),
        .io_in_rd(b_rd), .io_in_wr(b_wr), .io_in_addr(b_addr), .io_in_din(b_din),
        .io_in_dout(b_in_dout), .io_in_wait_n(b_in_wait_n), .io_in_valid(b_in_valid),
        .io_out_rd(b_out_rd), .io_out_wr(b_out_wr), .io_out_addr(b_out_addr), .io_out_din(b_out_din),
        .io_out_dout(b_out_dout), .io_out_wait_n(b_out_wait_n), .io_out_valid(b_out_valid),
        .pending(b_pending), .err_valid(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Channel i: address 0x10+i (A) / 0x20+i (B), write data 0x100+i.
        a_addr = {7'h13, 7'h12, 7'h11, 7'h10};
        b_addr = {7'h23, 7'h22, 7'h21, 7'h20};
        a_din  = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        b_din  = a_din;
        a_rd = '0; a_wr = '0; a_out_wait_n = 1'b1; a_out_valid = 1'b0; a_out_dout = '0;
        b_rd = '0; b_wr = '0; b_out_wait_n = 1'b1; b_out_valid = 1'b0; b_out_dout = '0;
        reset = 1'b1;

        // Reset state
        #2;
        chk("rst_pending", 32'(a_pending), 0);
        chk("rst_err", 32'(a_err), 0);
        chk("rst_wait_n", 32'(a_in_wait_n), 32'hf);
        chk("rst_out_rd", 32'(a_out_rd), 0);
        chk("rst_out_addr", 32'(a_out_addr), 0);
        chk("rst_in_valid", 32'(a_in_valid), 0);
        tick();
        reset = 1'b0;

        // Fixed priority: ch1 beats ch3, response two cycles later goes to ch1
        a_rd = 4'b1010; #1;
        chk("fix_out_rd", 32'(a_out_rd), 1);
        chk("fix_addr", 32'(a_out_addr), 32'h11);
        chk("fix_wait_n", 32'(a_in_wait_n), 32'b0010);
        tick();
        a_rd = '0; #1;
        chk("fix_pending", 32'(a_pending), 1);
        tick();
        a_out_valid = 1'b1; a_out_dout = 16'hBEEF; #1;
        chk("fix_valid", 32'(a_in_valid), 32'b0010);
        chk("fix_dout", 32'(a_in_dout[16 +: 16]), 32'hBEEF);
        tick();
        a_out_valid = 1'b0; #1;
        chk("fix_drain", 32'(a_pending), 0);

        // Read capacity limit: ch0, ch2, ch1 with no responses
        a_rd = 4'b0001; #1;
        chk("cap_rd0", 32'(a_out_rd), 1);
        tick();
        a_rd = 4'b0100; #1;
        chk("cap_rd2", 32'(a_out_addr), 32'h12);
        tick();
        a_rd = 4'b0010; #1;
        chk("cap_block_rd", 32'(a_out_rd), 0);
        chk("cap_block_wait", 32'(a_in_wait_n), 0);
        chk("cap_full", 32'(a_pending), 2);
        tick();
        a_out_valid = 1'b1; a_out_dout = 16'h1234; #1;
        chk("cap_ret0", 32'(a_in_valid), 32'b0001);
        chk("cap_still_blk", 32'(a_out_rd), 0);
        tick();
        a_out_valid = 1'b0; #1;
        chk("cap_accept_rd", 32'(a_out_rd), 1);
        chk("cap_accept_wait", 32'(a_in_wait_n), 32'b0010);
        tick();
        a_rd = '0; a_out_valid = 1'b1; #1;
        chk("cap_ret2", 32'(a_in_valid), 32'b0100);
        tick();
        #1;
        chk("cap_ret1", 32'(a_in_valid), 32'b0010);
        tick();
        a_out_valid = 1'b0; #1;
        chk("cap_empty", 32'(a_pending), 0);

        // Downstream stall locks the grant on ch2 even when ch0 joins
        a_rd = 4'b0100; a_out_wait_n = 1'b0; #1;
        chk("lock_addr0", 32'(a_out_addr), 32'h12);
        chk("lock_wait0", 32'(a_in_wait_n), 0);
        tick();
        a_rd = 4'b0101; #1;
        chk("lock_addr1", 32'(a_out_addr), 32'h12);
        tick();
        #1;
        chk("lock_addr2", 32'(a_out_addr), 32'h12);
        tick();
        a_out_wait_n = 1'b1; #1;
        chk("lock_addr3", 32'(a_out_addr), 32'h12);
        chk("lock_wait3", 32'(a_in_wait_n), 32'b0100);
        tick();
        a_rd = 4'b0001; #1;
        chk("lock_release", 32'(a_out_addr), 32'h10);
        tick();
        a_rd = '0; a_out_valid = 1'b1; #1;
        chk("lock_ret2", 32'(a_in_valid), 32'b0100);
        tick();
        #1;
        chk("lock_ret0", 32'(a_in_valid), 32'b0001);
        tick();
        a_out_valid = 1'b0; #1;
        chk("lock_empty", 32'(a_pending), 0);

        // Zero-latency read on ch3
        a_rd = 4'b1000; a_out_valid = 1'b1; a_out_dout = 16'hCAFE; #1;
        chk("zl_valid", 32'(a_in_valid), 32'b1000);
        chk("zl_dout", 32'(a_in_dout[48 +: 16]), 32'hCAFE);
        tick();
        a_rd = '0; a_out_valid = 1'b0; #1;
        chk("zl_pending", 32'(a_pending), 0);
        chk("zl_err", 32'(a_err), 0);

        // Stray response sets a sticky error
        a_out_valid = 1'b1; #1;
        chk("stray_no_valid", 32'(a_in_valid), 0);
        tick();
        a_out_valid = 1'b0; #1;
        chk("stray_err", 32'(a_err), 1);
        tick();
        #1;
        chk("stray_sticky", 32'(a_err), 1);

        // Round robin, four channels reading continuously, one-cycle memory
        b_rd = 4'b1111; #1;
        chk("rr_grant0", 32'(b_out_addr), 32'h20);
        chk("rr_valid0", 32'(b_in_valid), 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            b_out_valid = 1'b1; b_out_dout = 16'hD000 + 16'(k - 1); #1;
            chk("rr_grant", 32'(b_out_addr), 32'h20 + 32'(k % 4));
            chk("rr_valid", 32'(b_in_valid), 32'(1) << (k - 1));
            chk("rr_dout", 32'(b_in_dout[(k-1)*16 +: 16]), 32'hD000 + 32'(k - 1));
            chk("rr_pending", 32'(b_pending), 1);
        end
        tick();
        b_rd = '0; #1;
        chk("rr_last", 32'(b_in_valid), 32'b0001);
        tick();
        b_out_valid = 1'b0; #1;
        chk("rr_empty", 32'(b_pending), 0);

        // Stray on B, then three outstanding reads, then reset mid-burst
        b_out_valid = 1'b1;
        tick();
        b_out_valid = 1'b0; b_rd = 4'b0001; #1;
        chk("b_err_set", 32'(b_err), 1);
        tick();
        tick();
        tick();
        b_rd = '0; #1;
        chk("b_pending3", 32'(b_pending), 3);
        reset = 1'b1; #1;
        chk("arst_pending", 32'(b_pending), 0);
        chk("arst_err", 32'(b_err), 0);
        chk("arst_wait_n", 32'(b_in_wait_n), 32'hf);
        tick();
        reset = 1'b0;
        b_out_valid = 1'b1; #1;
        chk("late_resp_no_valid", 32'(b_in_valid), 0);
        tick();
        b_out_valid = 1'b0; #1;
        chk("late_resp_err", 32'(b_err), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/async_mem_arbiter_n.md
# async_mem_arbiter_n

Parametrised N-channel arbiter that multiplexes several asynchronous-memory clients onto one downstream port with rd/wr/addr/din/dout/wait_n/valid signalling. It replaces the two-channel, single-outstanding arbiter in the cave memory subsystem. New capabilities:
- configurable channel count and widths;
- fixed-priority or round-robin arbitration;
- up to MAX_PENDING outstanding reads, tracked in a channel-index FIFO so read data returns to the issuing channel.

## Interface
- N, 2: number of client channels (2..16).
- ADDR_WIDTH, 7: address width.
- DATA_WIDTH, 16: data width.
- MAX_PENDING, 4: outstanding read capacity (1..16).
- MODE, PRIO_FIXED: PRIO_FIXED (lowest index wins) or PRIO_RR (round-robin).

Ports:
- clock  in  1  sole clock; one clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- io_in_rd  in  N  per-channel read request.
- io_in_wr  in  N  per-channel write request.
- io_in_addr  in  N*ADDR_WIDTH  channel i at slice i.
- io_in_din  in  N*DATA_WIDTH  write data, channel i at slice i.
- io_in_dout  out  N*DATA_WIDTH  every slice = io_out_dout.
- io_in_wait_n  out  N  per-channel ready.
- io_in_valid  out  N  per-channel read-data strobe.
- io_out_rd, io_out_wr  out  1  downstream request.
- io_out_addr  out  ADDR_WIDTH  downstream address.
- io_out_din  out  DATA_WIDTH  downstream write data.
- io_out_dout  in  DATA_WIDTH  downstream read data.
- io_out_wait_n  in  1  downstream ready.
- io_out_valid  in  1  downstream read-data strobe.
- pending  out  $clog2(MAX_PENDING+1)  outstanding read count.
- err_valid  out  1  sticky: io_out_valid with nothing to return.

## Operation
Requests and grant:
- Channel i requests when io_in_rd[i] | io_in_wr[i]. rd and wr together on one channel are illegal; the arbiter forwards both, and this is not checked.
- Grant is combinational. If lock is set, grant = lock_idx. Otherwise PRIO_FIXED picks the lowest requesting index; PRIO_RR picks the first requesting index after rr_ptr, wrapping.
- Downstream outputs carry the granted channel's rd/wr/addr/din. With no grant, all downstream outputs are 0.

Stall and acceptance:
- read_block = granted rd & (pending == MAX_PENDING), computed from the registered count only.
- When read_block is set, io_out_rd is forced 0.
- Accept = grant present & request & io_out_wait_n & ~read_block.
- Granted request not accepted → lock set, lock_idx = grant. Lock clears on accept or when the locked channel drops its request.

Ready signals:
- io_in_wait_n[i] = io_out_wait_n & ~read_block & (no grant | grant == i).
- Non-granted requesters therefore see wait_n = 0.

Pointer update:
- On accept, rr_ptr ← grant. PRIO_RR only; the register exists in both modes.

Read return:
- Accepted read with FIFO non-empty, or with io_out_valid = 0: push grant index into the FIFO.
- Accepted read with FIFO empty and io_out_valid = 1 in the same cycle (zero-latency device): no push; valid and dout go to the granted channel.
- Otherwise io_out_valid pops the head and pulses io_in_valid[head].
- Push and pop in the same cycle: both happen, count unchanged.
- io_out_valid with FIFO empty and no zero-latency read: dropped, err_valid ← 1 until reset.

Writes:
- Never enter the FIFO and are accepted while reads are pending.
- The arbiter does no ordering; the downstream device handles ordering.

## Timing
- Grant, downstream request, wait_n and valid routing are all combinational: zero added latency in both directions.
- State: FIFO, count, rr_ptr, lock and lock_idx, err_valid, all updated on the rising clock edge.
- Reset (async, any time including mid-transaction):
  - FIFO empty, pending = 0, rr_ptr = N-1 (channel 0 first in RR), lock = 0, err_valid = 0.
  - Responses to reads in flight at reset are discarded: they are counted as err_valid only if they arrive after reset deasserts.
- With reset high and inputs idle, every output is 0 except io_in_wait_n, which equals io_out_wait_n for every channel.
- Throughput: one accepted request per cycle.
- With MAX_PENDING = 1, behaviour matches the single-outstanding predecessor, except that writes may proceed while a read is pending.

## Structure
- Package async_mem_arbiter_pkg holds:
  - enum arb_mode_t {PRIO_FIXED, PRIO_RR};
  - function rr_pick(req, ptr) returning the index and a found flag.
- Sub-module async_mem_index_fifo: synchronous FIFO of $clog2(N)-bit entries, depth MAX_PENDING, with push/pop/head/count. It stays internal; the arbiter derives read_block from its count.

## Test plan
- Fixed mode, N=4: rd on ch1 and ch3, wait_n=1 → ch1 granted, ch3 wait_n=0. Valid 2 cycles later → io_in_valid = 4'b0010.
- RR mode, N=4, all four channels reading continuously, 1-cycle memory → grant sequence 0,1,2,3,0 and each channel receives its own dout.
- MAX_PENDING=2: three back-to-back reads from ch0, ch2, ch1 with no valid → third request sees wait_n=0 and io_out_rd=0. First valid → returns to ch0 and the third read is accepted the next cycle.
- io_out_wait_n=0 for 3 cycles during a ch2 request while ch0 also requests in fixed mode → grant stays locked on ch2 until accept.
- Zero-latency read: accept and valid in the same cycle with FIFO empty → granted channel gets valid, pending stays 0, err_valid stays 0.
- Stray io_out_valid with pending=0 → err_valid rises and stays 1. Assert reset mid-burst with pending=3 → pending=0 and err_valid=0 immediately, without waiting for a clock edge.
